// File: rtl/puc_pkg.sv
// rtl/puc_pkg.sv - shared state encoding and sizing helpers for the power-up contract sequencer
package puc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_REQ,
    ST_SETTLE,
    ST_DONE,
    ST_ERR
  } puc_seq_state_t;

  localparam int N_PUC_DEFAULT = 2;

  // Index width used for err_idx_o; a single-domain build still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/puc_timer.sv
// rtl/puc_timer.sv - shared cycle counter with clear, increment and terminal-count compare
module puc_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Counter: clear has priority over increment so a phase change restarts from zero.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/puc_seq.sv
// rtl/puc_seq.sv - power-up contract sequencer; define PUC_SEQ_ACK_MON_EN to watch granted acks after bring-up
module puc_seq
  import puc_pkg::*;
#(
  parameter int N_PUC          = N_PUC_DEFAULT,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [N_PUC-1:0]           puc_i,
  input  logic                       start_i,
  output logic [N_PUC-1:0]           pwr_req_o,
  input  logic [N_PUC-1:0]           pwr_ack_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [idx_w(N_PUC)-1:0]    err_idx_o
);

  localparam int IDX_W = idx_w(N_PUC);
  localparam int CW    = $clog2(N_PUC + 1);
  localparam int TMAX  = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  puc_seq_state_t   state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [N_PUC-1:0] cap_q, cap_d;
  logic [N_PUC-1:0] req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;

  logic             tmr_clr, tmr_inc, tmr_tc;
  logic [TW-1:0]    tmr_tc_val;
  logic [N_PUC-1:0] cur_oh;
  logic             cap_bit, ack_bit;

  // One-hot of the domain being worked on; all-zero once idx walks past the last domain.
  assign cur_oh  = N_PUC'(1) << idx_q;
  assign cap_bit = |(cap_q & cur_oh);
  assign ack_bit = |(pwr_ack_i & cur_oh);

  assign tmr_tc_val = (state_q == ST_REQ) ? TW'(TIMEOUT_CYCLES - 1) : TW'(SETTLE_CYCLES - 1);

  puc_timer #(.W(TW)) u_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (tmr_clr),
    .inc_i    (tmr_inc),
    .tc_val_i (tmr_tc_val),
    .tc_o     (tmr_tc)
  );

`ifdef PUC_SEQ_ACK_MON_EN
  logic [N_PUC-1:0] drop;
  logic [N_PUC-1:0] drop_oh;
  logic [IDX_W-1:0] drop_idx;
  logic             drop_any;

  // Lowest granted domain whose ack has fallen away.
  always_comb begin
    drop     = req_q & ~pwr_ack_i;
    drop_any = |drop;
    drop_oh  = '0;
    drop_idx = '0;
    for (int j = N_PUC - 1; j >= 0; j--) begin
      if (drop[j]) begin
        drop_oh  = N_PUC'(1) << j;
        drop_idx = IDX_W'(j);
      end
    end
  end
`endif

  // State and output registers; every output is driven straight from a flop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cap_q     <= '0;
      req_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cap_q     <= cap_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Sequencing: walk the snapshot, request each contracted domain, wait for ack then settle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cap_d     = cap_q;
    req_d     = req_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cap_d   = puc_i;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (idx_q == CW'(N_PUC)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (!cap_bit) begin
          idx_d = idx_q + CW'(1);
        end else begin
          req_d   = req_q | cur_oh;
          tmr_clr = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack is tested before the timeout so an ack on the last allowed cycle still wins.
        if (ack_bit) begin
          tmr_clr = 1'b1;
          state_d = ST_SETTLE;
        end else if (tmr_tc) begin
          req_d     = req_q & ~cur_oh;
          err_idx_d = IDX_W'(idx_q);
          err_d     = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_ERR;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_SETTLE: begin
`ifdef PUC_SEQ_ACK_MON_EN
        if (drop_any) begin
          req_d     = req_q & ~drop_oh;
          err_idx_d = drop_idx;
          err_d     = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_ERR;
        end else
`endif
        if (tmr_tc) begin
          idx_d   = idx_q + CW'(1);
          state_d = ST_SCAN;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_DONE: begin
`ifdef PUC_SEQ_ACK_MON_EN
        if (drop_any) begin
          req_d     = req_q & ~drop_oh;
          err_idx_d = drop_idx;
          err_d     = 1'b1;
          done_d    = 1'b0;
          state_d   = ST_ERR;
        end
`endif
      end
      ST_ERR: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pwr_req_o = req_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_puc_seq.sv
// tb/tb_puc_seq.sv - scoreboard bench for puc_seq with an event-timeline reference model
module tb_puc_seq;

  localparam int N  = 2;
  localparam int ST = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] puc = '0;
  logic         start = 1'b0;
  logic [N-1:0] ack = '0;
  logic [N-1:0] pwr_req;
  logic         busy, done, err;
  logic         err_idx;

  puc_seq #(
    .N_PUC          (N),
    .SETTLE_CYCLES  (ST),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .puc_i     (puc),
    .start_i   (start),
    .pwr_req_o (pwr_req),
    .pwr_ack_i (ack),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .err_idx_o (err_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int       c;
    logic [1:0] req;
    logic     b;
    logic     d;
    logic     e;
    logic     x;
  } ev_t;

  ev_t  exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  logic [5:0] prev, cur, want;
  ev_t  mev;

  function automatic ev_t mk(input int c, input logic [1:0] r, input logic b, input logic d,
                             input logic e, input logic x);
    ev_t v;
    v.c = c; v.req = r; v.b = b; v.d = d; v.e = e; v.x = x;
    return v;
  endfunction

  // Monitor: each output change is one event and must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {pwr_req, busy, done, err, err_idx};
      if (cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change cyc=%0d outputs=%b required=no change", cyc, cur);
        end else begin
          mev  = exp_q.pop_front();
          want = {mev.req, mev.b, mev.d, mev.e, mev.x};
          if (mev.c != cyc || cur !== want) begin
            miscompares++;
            $display("FAIL event cyc=%0d required_cyc=%0d outputs{req,busy,done,err,idx}=%b required=%b",
                     cyc, mev.c, cur, want);
          end
        end
        prev = cur;
      end
    end
  end

  // One sequencing run. l0/l1: ack latency per domain (>TO means never acks).
  // rst_off: reset sampled rst_off edges after start (0 = none).
  // drop_off: ack[drop_j] dropped drop_off edges after done (0 = none).
  task automatic run_case(input logic [1:0] p, input int l0, input int l1, input int rst_off,
                          input int drop_j, input int drop_off);
    int   lat[2];
    int   ackset[2];
    int   s, t, r, dd, tend, done_t;
    logic [1:0] req;
    bit   errd;
    ev_t  evs[$];

    mon_en = 1'b0;
    ack    = '0;
    start  = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    puc = p;
    @(negedge clk);
    vectors++;
    if ({pwr_req, busy, done, err, err_idx} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_state outputs=%b required=000000", {pwr_req, busy, done, err, err_idx});
    end
    exp_q.delete();
    prev   = {pwr_req, busy, done, err, err_idx};
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    lat[0] = l0; lat[1] = l1;
    ackset[0] = -1; ackset[1] = -1;
    s = cyc + 2;
    t = s;
    req = '0;
    errd = 1'b0;
    done_t = -1;
    evs.push_back(mk(s, req, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int n = 0; n < N; n++) begin
      t++;
      if (!p[n]) continue;
      req[n] = 1'b1;
      evs.push_back(mk(t, req, 1'b1, 1'b0, 1'b0, 1'b0));
      if (lat[n] <= TO) begin
        ackset[n] = t + lat[n] - 1;
        t = t + lat[n] + ST;
      end else begin
        t = t + TO;
        req[n] = 1'b0;
        evs.push_back(mk(t, req, 1'b0, 1'b0, 1'b1, n[0]));
        errd = 1'b1;
        break;
      end
    end
    if (!errd) begin
      t++;
      evs.push_back(mk(t, req, 1'b0, 1'b1, 1'b0, 1'b0));
      done_t = t;
    end
    tend = t;

    dd = 0;
    if (drop_off > 0 && rst_off == 0 && done_t > 0 && p[drop_j]) begin
      dd = done_t + drop_off;
`ifdef PUC_SEQ_ACK_MON_EN
      evs.push_back(mk(dd, req & ~(2'b01 << drop_j), 1'b0, 1'b0, 1'b1, drop_j[0]));
`endif
      if (dd > tend) tend = dd;
    end

    r = 0;
    if (rst_off > 0) begin
      r = s + rst_off;
      foreach (evs[i]) if (evs[i].c < r) exp_q.push_back(evs[i]);
      exp_q.push_back(mk(r, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
      if (r > tend) tend = r;
    end else begin
      foreach (evs[i]) exp_q.push_back(evs[i]);
    end
    tend = tend + 4;

    while (cyc <= tend) begin
      start = (cyc == s - 1);
      reset = (r > 0 && cyc == r - 1);
      for (int n = 0; n < N; n++) if (ackset[n] >= 0 && cyc == ackset[n]) ack[n] = 1'b1;
      if (r > 0 && cyc >= r) ack = '0;
      if (dd > 0 && cyc == dd - 1) ack[drop_j] = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events remaining=%0d next_cyc=%0d required=0 remaining",
               exp_q.size(), exp_q[0].c);
    end
    mon_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    run_case(2'b11, 2, 2, 0, 0, 0);    // contract and ordering
    run_case(2'b10, 2, 3, 0, 0, 0);    // skip domain 0
    run_case(2'b11, 2, 99, 0, 0, 0);   // timeout on domain 1
    run_case(2'b11, 8, 8, 0, 0, 0);    // ack on the timeout cycle
    run_case(2'b11, 9, 1, 0, 0, 0);    // one past the timeout cycle
    run_case(2'b11, 1, 1, 0, 0, 0);    // minimum ack latency
    run_case(2'b00, 1, 1, 0, 0, 0);    // empty contract
    run_case(2'b11, 2, 2, 5, 0, 0);    // reset mid-SETTLE
    run_case(2'b11, 2, 2, 0, 0, 3);    // drop ack0 after done
    run_case(2'b01, 3, 3, 0, 0, 1);
    run_case(2'b11, 4, 2, 0, 1, 2);    // drop ack1 after done
    for (int k = 0; k < 40; k++) begin
      logic [1:0] p;
      int ro, dj, dof;
      p   = 2'($urandom_range(0, 3));
      ro  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
      dj  = int'($urandom_range(0, 1));
      dof = (ro == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      run_case(p, int'($urandom_range(1, 10)), int'($urandom_range(1, 10)), ro, dj, dof);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
